oserdes_word_gen: RTL and testbench

Parallel word source for an 8:1 DDR OSERDESE2 transmitter. It runs on the slow CLKDIV-rate clock and presents one 8-bit word per cycle on the serializer D1..D8 inputs. After enable it sends a fixed training preamble, then either a self-seeded PRBS7 stream or user words from a valid/ready input buffered in a small FIFO. If the FIFO runs dry in user mode it inserts idle words and counts underflows.

---
 rtl/serdes_tx_pkg.sv | 22 ++
 rtl/word_fifo.sv | 62 ++++++
 rtl/oserdes_word_gen.sv | 137 +++++++++++++
 tb/tb_oserdes_word_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_tx_pkg.sv
// Shared types and constants for the OSERDES transmit word path.
package serdes_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } tx_state_e;

  localparam logic [6:0] PRBS7_SEED   = 7'h7F;
  localparam int         PRBS7_TAP_HI = 6;
  localparam int         PRBS7_TAP_LO = 5;

  localparam logic [7:0] DEF_TRAIN_PATTERN = 8'hA5;
  localparam logic [7:0] DEF_IDLE_WORD     = 8'h00;

  // One PRBS7 (x^7+x^6+1) shift; the new bit lands in bit 0 and is the output bit.
  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO]};
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Small synchronous FIFO with flush; head word is visible combinationally.
module word_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           push,
  input  logic [DATA_WIDTH-1:0]          push_data,
  input  logic                           pop,
  output logic [DATA_WIDTH-1:0]          head_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic                  push_ok;
  logic                  pop_ok;

  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign head_data = mem[rd_ptr_reg];
  assign push_ok   = push && !full && !flush;
  assign pop_ok    = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/oserdes_word_gen.sv
// Parallel word source for an 8:1 OSERDES: training preamble, then PRBS7 or user FIFO payload.
module oserdes_word_gen
  import serdes_tx_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    FIFO_DEPTH    = 4,
  parameter int                    TRAIN_WORDS   = 64,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD     = DEF_IDLE_WORD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  prbs_mode,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  oce,
  output logic                  training,
  output logic                  underflow,
  output logic [15:0]           underflow_count
);

  localparam int CNT_W = $clog2(TRAIN_WORDS + 1);
  localparam int FCW   = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] TRAIN_LAST = CNT_W'(TRAIN_WORDS);

  tx_state_e             state_reg;
  logic [CNT_W-1:0]      train_cnt_reg;
  logic                  mode_reg;
  logic [6:0]            prbs_reg;

  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FCW-1:0]        fifo_count;
  logic                  push;
  logic                  pop;
  logic                  train_done;
  logic                  payload_cycle;

  logic [6:0]            prbs_chain [DATA_WIDTH+1];
  logic [DATA_WIDTH-1:0] prbs_word;

  // Unrolled PRBS: each bit advances the LFSR once; the state carries into the next word.
  assign prbs_chain[0] = prbs_reg;
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_prbs
      assign prbs_chain[gi+1] = prbs7_step(prbs_chain[gi]);
      assign prbs_word[gi]    = prbs_chain[gi+1][0];
    end
  endgenerate

  assign s_ready       = rst_n && enable && !fifo_full;
  assign push          = s_valid && s_ready;
  assign train_done    = (state_reg == ST_TRAIN) && (train_cnt_reg == TRAIN_LAST);
  assign payload_cycle = enable && ((state_reg == ST_RUN) || train_done);
  assign pop           = payload_cycle && !mode_reg && (fifo_count != '0);

  word_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (!enable),
    .push      (push),
    .push_data (s_data),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      train_cnt_reg   <= '0;
      mode_reg        <= 1'b0;
      prbs_reg        <= PRBS7_SEED;
      d_out           <= IDLE_WORD;
      oce             <= 1'b0;
      training        <= 1'b0;
      underflow       <= 1'b0;
      underflow_count <= '0;
    end else begin
      underflow <= 1'b0;
      if (!enable) begin
        state_reg     <= ST_IDLE;
        train_cnt_reg <= '0;
        d_out         <= IDLE_WORD;
        oce           <= 1'b0;
        training      <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            state_reg     <= ST_TRAIN;
            mode_reg      <= prbs_mode;
            prbs_reg      <= PRBS7_SEED;
            train_cnt_reg <= CNT_W'(1);
            d_out         <= TRAIN_PATTERN;
            oce           <= 1'b1;
            training      <= 1'b1;
          end
          default: begin
            oce <= 1'b1;
            if (!payload_cycle) begin
              train_cnt_reg <= train_cnt_reg + 1'b1;
              d_out         <= TRAIN_PATTERN;
              training      <= 1'b1;
            end else begin
              // First payload word leaves on the same edge that enters RUN.
              state_reg <= ST_RUN;
              training  <= 1'b0;
              if (mode_reg) begin
                d_out    <= prbs_word;
                prbs_reg <= prbs_chain[DATA_WIDTH];
              end else if (!fifo_empty) begin
                d_out <= fifo_head;
              end else begin
                d_out     <= IDLE_WORD;
                underflow <= 1'b1;
                if (underflow_count != 16'hFFFF) begin
                  underflow_count <= underflow_count + 1'b1;
                end
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oserdes_word_gen.sv
// Scoreboard bench: a behavioural model queues the expected word per cycle, compared one edge later.
module tb_oserdes_word_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        prbs_mode = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  d_out;
  logic        oce;
  logic        training;
  logic        underflow;
  logic [15:0] underflow_count;

  always #5 clk = ~clk;

  oserdes_word_gen dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .prbs_mode       (prbs_mode),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .d_out           (d_out),
    .oce             (oce),
    .training        (training),
    .underflow       (underflow),
    .underflow_count (underflow_count)
  );

  typedef struct {
    logic [7:0]  d;
    logic        oce;
    logic        trn;
    logic        uf;
    logic [15:0] uc;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] src_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          m_state;
  int          m_cnt;
  bit          m_mode;
  logic [6:0]  m_prbs;
  logic [7:0]  m_fifo[$];
  logic [15:0] m_uc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_prbs_word();
    logic [7:0] w;
    logic b;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      b = m_prbs[6] ^ m_prbs[5];
      m_prbs = {m_prbs[5:0], b};
      w[i] = b;
    end
    return w;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_mode  = 1'b0;
    m_prbs  = 7'h7F;
    m_fifo.delete();
    m_uc    = 16'h0000;
  endtask

  task automatic step(input string tag);
    exp_t e, g;
    bit   exp_ready, do_push;
    s_valid = (src_q.size() > 0);
    s_data  = s_valid ? src_q[0] : 8'h00;
    exp_ready = enable && (m_fifo.size() < 4);
    #1;
    check({tag, "/s_ready"}, s_ready, exp_ready);
    do_push = s_valid && exp_ready;
    e.uf = 1'b0;
    if (!enable) begin
      m_state = 0; m_cnt = 0; m_fifo.delete();
      e.d = 8'h00; e.oce = 1'b0; e.trn = 1'b0;
    end else if (m_state == 0) begin
      m_state = 1; m_mode = prbs_mode; m_prbs = 7'h7F; m_cnt = 1;
      e.d = 8'hA5; e.oce = 1'b1; e.trn = 1'b1;
    end else if (m_state == 1 && m_cnt < 64) begin
      m_cnt++;
      e.d = 8'hA5; e.oce = 1'b1; e.trn = 1'b1;
    end else begin
      m_state = 2; e.oce = 1'b1; e.trn = 1'b0;
      if (m_mode) e.d = ref_prbs_word();
      else if (m_fifo.size() > 0) e.d = m_fifo.pop_front();
      else begin
        e.d = 8'h00; e.uf = 1'b1;
        if (m_uc != 16'hFFFF) m_uc++;
      end
    end
    e.uc = m_uc;
    if (do_push) begin
      m_fifo.push_back(s_data);
      void'(src_q.pop_front());
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    check({tag, "/d_out"}, d_out, g.d);
    check({tag, "/oce"}, oce, g.oce);
    check({tag, "/training"}, training, g.trn);
    check({tag, "/underflow"}, underflow, g.uf);
    check({tag, "/ucount"}, underflow_count, g.uc);
    $display("%-10s d_out=%02h oce=%0b trn=%0b uf=%0b ucnt=%0d rdy=%0b",
             tag, d_out, oce, training, underflow, underflow_count, s_ready);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "/d_out"}, d_out, 8'h00);
    check({tag, "/oce"}, oce, 1'b0);
    check({tag, "/training"}, training, 1'b0);
    check({tag, "/underflow"}, underflow, 1'b0);
    check({tag, "/ucount"}, underflow_count, 16'h0000);
    check({tag, "/s_ready"}, s_ready, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

    // Idle with enable low
    repeat (10) step("idle");

    // PRBS mode: 64 training words then 1000 PRBS words
    prbs_mode = 1'b1; enable = 1'b1;
    repeat (64) step("train");
    step("prbs");
    check("prbs_first", d_out, 8'h40);
    step("prbs");
    check("prbs_second", d_out, 8'h30);
    repeat (998) step("prbs");

    // FIFO mode with three words pushed while training
    enable = 1'b0;
    repeat (2) step("idle");
    prbs_mode = 1'b0; enable = 1'b1;
    src_q = '{8'h11, 8'h22, 8'h33};
    repeat (64) step("train");
    step("run");
    check("fifo_first", d_out, 8'h11);
    repeat (2) step("run");
    repeat (5) step("uflow");

    // Continuous valid in RUN: ready must hold
    repeat (30) begin
      src_q.push_back(8'($urandom));
      step("stream");
    end

    // Prefill during TRAIN until full, keep feeding, then drop enable with FIFO at 3
    enable = 1'b0;
    repeat (2) step("idle");
    enable = 1'b1;
    for (int i = 0; i < 16; i++) src_q.push_back(8'(8'h60 + i));
    repeat (64) step("fill");
    repeat (6) step("drain");
    enable = 1'b0;
    step("drop");
    src_q.delete();
    step("idle");
    enable = 1'b1;
    repeat (64) step("train");
    step("flushed");
    check("flush_empty", underflow, 1'b1);

    // Re-enable in PRBS mode: PRBS restarts from the seed
    enable = 1'b0;
    step("idle");
    prbs_mode = 1'b1; enable = 1'b1;
    repeat (64) step("train");
    step("prbs");
    check("prbs_restart", d_out, 8'h40);
    repeat (5) step("prbs");

    // Asynchronous reset in the middle of TRAIN
    enable = 1'b0;
    step("idle");
    enable = 1'b1;
    repeat (20) step("train");
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    enable = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_values("rst_held");
    rst_n = 1'b1;
    repeat (10) step("idle");
    enable = 1'b1;
    repeat (64) step("train");
    step("prbs");
    check("prbs_after_rst", d_out, 8'h40);
    repeat (20) step("prbs");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
